// File: rtl/pc_gen_stage_if.sv
// pc_gen_stage_if: redirect inputs and fetch-facing outputs of the PC stage.
// Perf counter outputs exist only when PC_GEN_PERF_EN is defined.
interface pc_gen_stage_if;
   logic        stall;
   logic        br_valid;
   logic [31:0] br_target;
   logic        id_is_branch;
   logic        exc_valid;
   logic        eret_valid;
   logic [31:0] epc;
   logic [31:0] inst_sram_addr;
   logic [31:0] PC_next;
   logic        PC_AdEL;
   logic        DSI;
   logic        IRWrite;
`ifdef PC_GEN_PERF_EN
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_redir_cnt;
`endif

   modport master (
      input  stall,
      input  br_valid,
      input  br_target,
      input  id_is_branch,
      input  exc_valid,
      input  eret_valid,
      input  epc,
      output inst_sram_addr,
      output PC_next,
      output PC_AdEL,
      output DSI,
      output IRWrite
`ifdef PC_GEN_PERF_EN
      ,
      output perf_stall_cnt,
      output perf_redir_cnt
`endif
   );

   modport slave (
      output stall,
      output br_valid,
      output br_target,
      output id_is_branch,
      output exc_valid,
      output eret_valid,
      output epc,
      input  inst_sram_addr,
      input  PC_next,
      input  PC_AdEL,
      input  DSI,
      input  IRWrite
`ifdef PC_GEN_PERF_EN
      ,
      input  perf_stall_cnt,
      input  perf_redir_cnt
`endif
   );
endinterface

// File: rtl/pc_gen_stage.sv
// pc_gen_stage: fetch PC owner, drives inst_sram address one cycle ahead.
// Optional perf counters enabled by defining PC_GEN_PERF_EN.
module pc_gen_stage #(
   parameter logic [31:0] RESET_ADDR = 32'hbfc00000,
   parameter logic [31:0] EXC_ADDR   = 32'hbfc00380
) (
   input logic              clk,
   input logic              rst,
   pc_gen_stage_if.master   bus
);

   localparam logic [0:0] RUN  = 1'b0;
   localparam logic [0:0] PEND = 1'b1;

   logic [31:0] pc;
   logic [31:0] pend_target;
   logic [31:0] npc;
   logic [0:0]  state;
   logic        redir;
   logic        flush;

   assign flush = bus.exc_valid | bus.eret_valid;

   // next-PC priority mux: exception, eret, pending, branch, hold, +4
   always_comb begin
      npc   = pc + 32'd4;
      redir = 1'b0;
      if (bus.exc_valid) begin
         npc   = EXC_ADDR;
         redir = 1'b1;
      end else if (bus.eret_valid) begin
         npc   = bus.epc;
         redir = 1'b1;
      end else if (state == PEND && !bus.stall) begin
         npc   = pend_target;
         redir = 1'b1;
      end else if (bus.br_valid && !bus.stall) begin
         npc   = bus.br_target;
         redir = 1'b1;
      end else if (bus.stall) begin
         npc   = pc;
      end
   end

   // PC register and pending-branch tracker
   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_ADDR;
         state       <= RUN;
         pend_target <= 32'd0;
      end else begin
         pc <= npc;
         if (state == RUN) begin
            if (bus.br_valid && bus.stall && !flush) begin
               state       <= PEND;
               pend_target <= bus.br_target;
            end
         end else begin
            if (!bus.stall || flush) begin
               state <= RUN;
            end
         end
      end
   end

   assign bus.inst_sram_addr = rst ? RESET_ADDR
                                   : {npc[31:2], 2'b00};
   assign bus.PC_next        = pc;
   assign bus.PC_AdEL        = |pc[1:0];
   assign bus.IRWrite        = ~rst & (~bus.stall | flush);
   assign bus.DSI            = ~rst & bus.id_is_branch & ~flush;

`ifdef PC_GEN_PERF_EN
   logic [31:0] stall_cnt;
   logic [31:0] redir_cnt;

   // cycles with the fetch register held, and redirected cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= 32'd0;
         redir_cnt <= 32'd0;
      end else begin
         if (!bus.IRWrite) stall_cnt <= stall_cnt + 32'd1;
         if (redir)        redir_cnt <= redir_cnt + 32'd1;
      end
   end

   assign bus.perf_stall_cnt = stall_cnt;
   assign bus.perf_redir_cnt = redir_cnt;
`endif

endmodule
